// File: rtl/mul_table_pipe.sv
// Lookup-table multiplier: an init FSM fills the a*b table with shift/add after reset or reinit,
// then operands stream through a valid/ready pipe with one-cycle latency. Define MUL_TABLE_SIGNED_EN for two's complement.
module mul_table_pipe #(
  parameter int A_W   = 3,
  parameter int B_W   = 3,
  parameter int RES_W = A_W + B_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reinit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             init_done
);

  localparam int AB_W  = A_W + B_W;
  localparam int DEPTH = 1 << AB_W;

  localparam logic [AB_W-1:0]  IDX_ONE  = {{(AB_W-1){1'b0}}, 1'b1};
  localparam logic [AB_W-1:0]  IDX_LAST = {AB_W{1'b1}};
  localparam logic [B_W-1:0]   B_ONE    = {{(B_W-1){1'b0}}, 1'b1};
  localparam logic [B_W-1:0]   B_ZERO   = {B_W{1'b0}};
  localparam logic [RES_W-1:0] RES_ZERO = {RES_W{1'b0}};
`ifdef MUL_TABLE_SIGNED_EN
  localparam logic [B_W-1:0]   B_HALF   = {1'b1, {(B_W-1){1'b0}}};
`endif

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Handshake: a beat moves on a rising edge where its valid and ready are both high;
  // in_ready depends on out_ready so a full output register can pop and refill in one cycle.
  state_t           state;
  logic [AB_W-1:0]  idx;
  logic [RES_W-1:0] sum;
  logic [RES_W-1:0] sum_next;
  logic [RES_W-1:0] table_mem [DEPTH];

  logic [A_W-1:0]   ai;
  logic [B_W-1:0]   bi;
  logic [B_W-1:0]   bi_next;
  logic [RES_W-1:0] ai_ext;
  logic [AB_W-1:0]  rd_addr;
  logic             push;

  assign ai      = idx[AB_W-1:B_W];
  assign bi      = idx[B_W-1:0];
  assign rd_addr = {a, b};

`ifdef MUL_TABLE_SIGNED_EN
  assign ai_ext = {{B_W{ai[A_W-1]}}, ai};
`else
  assign ai_ext = {{B_W{1'b0}}, ai};
`endif

  assign in_ready = (state == ST_RUN) && !reinit && (!out_valid || out_ready);
  assign push     = in_valid && in_ready;

  // Running product for the entry written next cycle: sum tracks ai*bi across the bi sweep.
  always_comb begin
    bi_next  = bi + B_ONE;
    sum_next = sum + ai_ext;
    if (bi_next == B_ZERO) begin
      sum_next = RES_ZERO;
`ifdef MUL_TABLE_SIGNED_EN
    end else if (bi_next == B_HALF) begin
      // bi jumps to its most negative value: restart from ai * -(2**(B_W-1))
      sum_next = RES_ZERO - (ai_ext << (B_W - 1));
`endif
    end
  end

  // Table storage has no reset; its contents are only trusted once init_done is high.
  always_ff @(posedge clk) begin
    if (rst_n && !reinit && (state == ST_INIT)) begin
      table_mem[idx] <= sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      idx       <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      init_done <= 1'b0;
    end else if (reinit) begin
      state     <= ST_INIT;
      idx       <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      idx <= idx + IDX_ONE;
      sum <= sum_next;
      if (idx == IDX_LAST) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end else begin
      if (push) begin
        result    <= table_mem[rd_addr];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
